// File: rtl/aes_stream_pkg.sv
// Shared definitions for the AES output streaming path.
//   state_e        : serializer FSM states
//   WORDS_PER_BLK  : stream words per RAM block
//   AXIS_WIDTH     : stream word width
//   BLK_WIDTH      : RAM block width
package aes_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LOAD,
    SEND,
    DONE
  } state_e;

  localparam int WORDS_PER_BLK = 4;
  localparam int AXIS_WIDTH    = 32;
  localparam int BLK_WIDTH     = 128;

endpackage

// File: rtl/bram_block_serializer.sv
// bram_block_serializer
// Reads a run of consecutive 128-bit blocks from the block RAM's synchronous
// read port and emits each as four 32-bit AXI4-Stream words, block bits
// [0:31] first, with tlast on the final word of the run.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start             : command strobe, sampled only in IDLE
//   base_addr         : first RAM address (captured with start)
//   blk_count         : number of blocks, 0..2^ADDR_WIDTH (captured with start)
//   bram_addr/_r_e    : RAM read address / read enable
//   bram_data         : RAM registered read data (one cycle after r_e)
//   m_axis_*          : master stream (tdata, tvalid, tready, tlast)
//   busy              : run in progress, drops together with done
//   done              : one-cycle pulse at run end
//
// Build option: define BRAM_SERIALIZER_PREFETCH_EN to fetch the next block
// while the current one is streaming, giving gap-free output.
module bram_block_serializer #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 128,
  parameter int AXIS_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   blk_count,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_r_e,
  input  logic [0:DATA_WIDTH-1] bram_data,
  output logic [AXIS_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done
);
  import aes_stream_pkg::*;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;    // next address to read
  logic [ADDR_WIDTH:0]   remain_q;  // blocks not yet read from RAM
  logic [0:DATA_WIDTH-1] shreg_q;
  logic [1:0]            idx_q;
  logic                  tvalid_q;
  logic                  r_e_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  pf_q;      // a prefetched block is waiting on bram_data

  logic hs;
  logic last_word;

  assign hs        = tvalid_q & m_axis_tready;
  assign last_word = (idx_q == 2'(WORDS_PER_BLK - 1));

  assign bram_addr     = addr_q;
  assign bram_r_e      = r_e_q;
  assign m_axis_tdata  = shreg_q[0:AXIS_WIDTH-1];
  assign m_axis_tvalid = tvalid_q;
  // Final word of the run: nothing left to read and nothing held in prefetch.
  assign m_axis_tlast  = tvalid_q & last_word & (remain_q == '0) & ~pf_q;
  assign busy          = busy_q;
  assign done          = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      shreg_q  <= '0;
      idx_q    <= '0;
      tvalid_q <= 1'b0;
      r_e_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pf_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q   <= base_addr;
            remain_q <= blk_count;
            busy_q   <= 1'b1;
            if (blk_count == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= READ;
              r_e_q   <= 1'b1;
            end
          end
        end
        READ: begin
          // Address/count advance as soon as the read is issued.
          r_e_q    <= 1'b0;
          addr_q   <= addr_q + 1'b1;
          remain_q <= remain_q - 1'b1;
          state_q  <= LOAD;
        end
        LOAD: begin
          shreg_q  <= bram_data;
          idx_q    <= '0;
          tvalid_q <= 1'b1;
          state_q  <= SEND;
`ifdef BRAM_SERIALIZER_PREFETCH_EN
          if (remain_q != '0) r_e_q <= 1'b1;
`endif
        end
        SEND: begin
`ifdef BRAM_SERIALIZER_PREFETCH_EN
          // Prefetch read was issued this cycle; RAM output holds it until used.
          if (r_e_q) begin
            r_e_q    <= 1'b0;
            addr_q   <= addr_q + 1'b1;
            remain_q <= remain_q - 1'b1;
            pf_q     <= 1'b1;
          end
`endif
          if (hs) begin
            idx_q   <= idx_q + 2'd1;
            shreg_q <= {shreg_q[AXIS_WIDTH:DATA_WIDTH-1], {AXIS_WIDTH{1'b0}}};
            if (last_word) begin
              if (pf_q) begin
                // Back-to-back block: reload directly and keep streaming.
                shreg_q <= bram_data;
                pf_q    <= 1'b0;
                if (remain_q != '0) r_e_q <= 1'b1;
              end else if (remain_q != '0) begin
                tvalid_q <= 1'b0;
                r_e_q    <= 1'b1;
                state_q  <= READ;
              end else begin
                tvalid_q <= 1'b0;
                done_q   <= 1'b1;
                state_q  <= DONE;
              end
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_block_serializer.sv
module tb_bram_block_serializer;
  localparam int AW = 9;
`ifdef BRAM_SERIALIZER_PREFETCH_EN
  localparam int GAP = 0;
`else
  localparam int GAP = 2;
`endif

  logic          clk = 1'b0;
  logic          reset, start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   blk_count;
  logic [AW-1:0] bram_addr;
  logic          bram_r_e;
  logic [0:127]  bram_data;
  logic [31:0]   m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast, busy, done;

  always #5 clk = ~clk;

  bram_block_serializer dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .blk_count(blk_count), .bram_addr(bram_addr), .bram_r_e(bram_r_e),
    .bram_data(bram_data), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .busy(busy), .done(done)
  );

  // RAM model: registered read port
  logic [0:127] mem [512];
  always @(posedge clk) if (bram_r_e) bram_data <= mem[bram_addr];

  typedef struct { logic [31:0] d; logic l; } exp_t;
  typedef struct { int base; int cnt; bit rnd; int exp_words; int exp_gap; } vec_t;

  exp_t sb[$];
  int   rd_addr_q[$];
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0;
  bit   rnd_rdy = 0;
  int   hs_cnt, gap_cur, gap_max, vld_cycles, last_hs_cyc;
  bit   seen_vld, prev_stall;
  logic [31:0] st_d;
  logic        st_l;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rnd_rdy) m_axis_tready = ($urandom_range(0, 3) != 0);
  end

  // Monitor / scoreboard consumer
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset) prev_stall = 1'b0;
    else begin
      if (bram_r_e) rd_addr_q.push_back(int'(bram_addr));
      if (prev_stall) begin
        check("hold_valid", 64'(m_axis_tvalid), 64'd1);
        check("hold_data", 64'(m_axis_tdata), 64'(st_d));
        check("hold_last", 64'(m_axis_tlast), 64'(st_l));
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      st_d = m_axis_tdata;
      st_l = m_axis_tlast;
      if (m_axis_tvalid) begin
        seen_vld = 1'b1;
        vld_cycles++;
        if (gap_cur > gap_max) gap_max = gap_cur;
        gap_cur = 0;
      end else if (seen_vld && busy && !done) gap_cur++;
      if (m_axis_tvalid && m_axis_tready) begin
        hs_cnt++;
        if (m_axis_tlast) last_hs_cyc = cyc;
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_word: got %0h expected none", m_axis_tdata);
        end else begin
          e = sb.pop_front();
          check("tdata", 64'(m_axis_tdata), 64'(e.d));
          check("tlast", 64'(m_axis_tlast), 64'(e.l));
        end
      end
    end
  end

  task automatic push_exp(input int b, input int c);
    logic [0:127] blk;
    for (int k = 0; k < c; k++) begin
      blk = mem[(b + k) % 512];
      for (int w = 0; w < 4; w++) sb.push_back('{blk[w*32 +: 32], (k == c - 1) && (w == 3)});
    end
  endtask

  task automatic run(input int b, input int c, input bit rnd, input int exp_gap,
                     input int ign_at, input bit lat);
    int t;
    rd_addr_q.delete();
    hs_cnt = 0; gap_cur = 0; gap_max = 0; vld_cycles = 0; seen_vld = 0;
    push_exp(b, c);
    rnd_rdy = rnd;
    m_axis_tready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(b); blk_count = (AW+1)'(c);
    @(posedge clk); #1;
    start = 1'b0;
    if (lat) begin
      check("lat_r_e", 64'(bram_r_e), 64'd1);
      check("lat_addr", 64'(bram_addr), 64'(b));
      check("lat_busy", 64'(busy), 64'd1);
      check("lat_vld_n1", 64'(m_axis_tvalid), 64'd0);
      @(posedge clk); #1;
      check("lat_vld_n2", 64'(m_axis_tvalid), 64'd0);
      @(posedge clk); #1;
      check("lat_vld_n3", 64'(m_axis_tvalid), 64'd1);
      check("lat_word0", 64'(m_axis_tdata), 64'h00112233);
    end
    t = 0;
    while (!done && t < 3000) begin
      @(negedge clk);
      t++;
      start = (t == ign_at);
    end
    start = 1'b0;
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL done_timeout: got no done expected done within 3000 cycles");
    end else check("done_timing", 64'(cyc), 64'(last_hs_cyc + 1));
    @(negedge clk);
    check("busy_after", 64'(busy), 64'd0);
    check("done_pulse", 64'(done), 64'd0);
    check("word_count", 64'(hs_cnt), 64'(c * 4));
    check("sb_empty", 64'(sb.size()), 64'd0);
    check("rd_count", 64'(rd_addr_q.size()), 64'(c));
    for (int k = 0; k < c && k < rd_addr_q.size(); k++)
      check("rd_addr", 64'(rd_addr_q[k]), 64'((b + k) % 512));
    check("gap", 64'(gap_max), 64'(exp_gap));
    if (!rnd) check("vld_cycles", 64'(vld_cycles), 64'(c * 4));
    rnd_rdy = 0;
    @(posedge clk); #1;
    m_axis_tready = 1'b1;
  endtask

  initial begin
    vec_t vecs[6];
    int t;
    vecs[0] = '{5,   1, 0, 4,  0};
    vecs[1] = '{511, 2, 0, 8,  GAP};
    vecs[2] = '{100, 3, 1, 12, GAP};
    vecs[3] = '{200, 4, 0, 16, GAP};
    vecs[4] = '{510, 3, 1, 12, GAP};
    vecs[5] = '{7,   1, 1, 4,  0};

    for (int i = 0; i < 512; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    mem[5] = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    reset = 1'b1; start = 1'b0; base_addr = '0; blk_count = '0; m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outs", 64'({bram_addr, bram_r_e, m_axis_tdata, m_axis_tvalid, m_axis_tlast, busy, done}), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Table-driven runs
    for (int i = 0; i < 6; i++)
      run(vecs[i].base, vecs[i].cnt, vecs[i].rnd, vecs[i].exp_gap, -1, i == 0);

    // start pulsed mid-run must be ignored
    run(30, 2, 0, GAP, 4, 0);
    repeat (10) @(posedge clk);
    check("ign_no_reads", 64'(rd_addr_q.size()), 64'd2);

    // Zero-length run
    rd_addr_q.delete();
    @(posedge clk); #1;
    start = 1'b1; base_addr = '0; blk_count = '0;
    @(posedge clk); #1;
    start = 1'b0;
    check("z_done", 64'(done), 64'd1);
    check("z_r_e", 64'(bram_r_e), 64'd0);
    check("z_vld", 64'(m_axis_tvalid), 64'd0);
    @(posedge clk); #1;
    check("z_done_clr", 64'(done), 64'd0);
    check("z_vld2", 64'(m_axis_tvalid), 64'd0);
    check("z_no_reads", 64'(rd_addr_q.size()), 64'd0);

    // Reset in the middle of a 3-block run
    hs_cnt = 0;
    push_exp(50, 3);
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(50); blk_count = (AW+1)'(3);
    @(posedge clk); #1;
    start = 1'b0;
    t = 0;
    while (hs_cnt < 2 && t < 100) begin @(posedge clk); t++; end
    check("rst_mid_reached", 64'(hs_cnt >= 2), 64'd1);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("rstm_addr", 64'(bram_addr), 64'd0);
    check("rstm_r_e", 64'(bram_r_e), 64'd0);
    check("rstm_data", 64'(m_axis_tdata), 64'd0);
    check("rstm_vld_last", 64'({m_axis_tvalid, m_axis_tlast}), 64'd0);
    check("rstm_busy_done", 64'({busy, done}), 64'd0);
    reset = 1'b0;
    sb.delete();
    repeat (3) begin
      @(negedge clk);
      check("rstm_quiet", 64'({done, m_axis_tvalid, m_axis_tlast}), 64'd0);
    end
    run(60, 2, 0, GAP, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_block_serializer.md
# bram_block_serializer

Downstream reader for the 128-bit block RAM. On a start command it reads a run of consecutive 128-bit blocks from the RAM's synchronous read port and emits each block as four 32-bit AXI4-Stream words, asserting `tlast` on the final word of the run. It sits between the cipher-output block RAM and the DMA-facing master stream.

## Interface
Parameters:
- `ADDR_WIDTH`, 9: RAM address width.
- `DATA_WIDTH`, 128: RAM word width. Fixed at 128.
- `AXIS_WIDTH`, 32: stream word width. Fixed at 32.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle command strobe; sampled only in IDLE.
- `base_addr`  in  ADDR_WIDTH  first RAM address; captured with `start`.
- `blk_count`  in  ADDR_WIDTH+1  number of blocks; captured with `start`.
- `bram_addr`  out  ADDR_WIDTH  RAM address.
- `bram_r_e`  out  1  RAM read enable.
- `bram_data`  in  [0:127]  RAM registered read data, valid one cycle after `bram_r_e`.
- `m_axis_tdata`  out  32  stream data.
- `m_axis_tvalid`  out  1  stream valid.
- `m_axis_tready`  in  1  stream ready.
- `m_axis_tlast`  out  1  last word of the run.
- `busy`  out  1  high from `start` acceptance until `done`.
- `done`  out  1  one-cycle pulse at run end.

## Operation
- States:
  - IDLE → READ on `start` with `blk_count` != 0.
  - IDLE → DONE on `start` with `blk_count` == 0.
  - READ → LOAD.
  - LOAD → SEND.
  - SEND → READ after the 4th word handshake when blocks remain.
  - SEND → DONE after the 4th word handshake of the last block.
  - DONE → IDLE.
- READ: `bram_r_e`=1, `bram_addr`=current address. The block never drives the RAM write port; the upstream writer must not write while `busy` is high.
- LOAD: `bram_data` is registered into a 128-bit shift register; word index is cleared.
- SEND: `tdata` = bits [0:31] of the shift register, so block bits [0:31] go out first. Each handshake (`tvalid && tready`) shifts left by 32 and increments the word index (2-bit counter).
- `tlast`=1 only on word 3 of the final block.
- Address increments by 1 per block and wraps modulo 2^ADDR_WIDTH, e.g. base 511, count 2 reads 511 then 0.
- `start` is ignored outside IDLE.
- `blk_count` max is 2^ADDR_WIDTH; the counter is ADDR_WIDTH+1 bits wide.

## Timing
- Reset values: `bram_addr`=0, `bram_r_e`=0, `m_axis_tdata`=0, `m_axis_tvalid`=0, `m_axis_tlast`=0, `busy`=0, `done`=0; state IDLE.
- Reset mid-run: the block returns to IDLE on the next edge and the partial run is discarded. No `done`, no `tlast`.
- Latency: `start` sampled at edge N; `bram_r_e` high in cycle N+1; first `tvalid` in cycle N+3.
- Gap between blocks without prefetch: `tvalid` low for 2 cycles (READ, LOAD).
- AXIS rules: once `tvalid` is high, `tdata` and `tlast` hold until the handshake. `tvalid` never depends combinationally on `tready`.
- `done` pulses the cycle after the final handshake. `busy` falls together with `done`.

## Configuration
- `BRAM_SERIALIZER_PREFETCH_EN` defined:
  - In the first SEND cycle of a block with blocks remaining, `bram_r_e` pulses for the next address. The RAM holds that output.
  - On the 4th handshake, the shift register loads `bram_data` directly and the FSM stays in SEND.
  - Result: zero-gap streaming of 4 words per 4 cycles under constant `tready`.
- Undefined: strict READ/LOAD/SEND sequence as specified above.

## Structure
- Shared package `aes_stream_pkg`:
  - FSM state enum (IDLE, READ, LOAD, SEND, DONE).
  - `WORDS_PER_BLK`=4.
  - `AXIS_WIDTH`=32 and `BLK_WIDTH`=128 constants.
- Single flat module; no sub-module. The shift register and counters are too small to split out.

## Test plan
- Preload RAM[5]=0x00112233_44556677_8899AABB_CCDDEEFF; start base=5, count=1, `tready`=1 → words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF; `tlast` on the 4th; `done` 1 cycle later; first `tvalid` 3 cycles after `start`.
- base=511, count=2 → reads at addresses 511 then 0; 8 words; `tlast` only on word 8.
- Randomised `tready` backpressure, count=3 → `tdata`/`tlast` stable while stalled; 12 words in order, none lost or duplicated.
- count=0 → no `bram_r_e`, no `tvalid`; `done` pulses the cycle after `start`; `start` pulses while `busy` are ignored.
- `reset` asserted after 2 words of a 3-block run → all outputs at reset values next cycle; a new `start` then works normally.
- With `BRAM_SERIALIZER_PREFETCH_EN`, count=4, `tready`=1 → 16 consecutive valid cycles with no gap.
